// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// The optional misalignment trap is enabled by defining DMEM_MISALIGN_TRAP_EN.
package dmem_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] STORE_RDATA = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;
endpackage

// File: rtl/dmem_array.sv
// DEPTH x WORD_W data storage: synchronous write, combinational read, no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MEM stage, with pipeline stall.
// Defining DMEM_MISALIGN_TRAP_EN adds the misalign_err response flag.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              stall,
`ifdef DMEM_MISALIGN_TRAP_EN
  output logic              misalign_err,
`endif
  output state_e            dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'((LATENCY >= 2) ? LATENCY - 2 : 0);

  // Handshake: a request transfers on a rising edge with req_valid && req_ready;
  // ready is high only in IDLE, and requests seen in BUSY/RESP are dropped.
  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q;
  logic [AW-1:0]     idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic              accept, enter_resp;
  logic              cur_write, cur_mis, mem_we;
  logic [AW-1:0]     cur_idx;
  logic [WORD_W-1:0] cur_wdata, mem_rdata;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
  assign accept = (state_q == IDLE) && req_valid;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    req_ready  = 1'b0;
    stall      = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // With LATENCY=1 the response is entered on the accepting edge, so the live
  // request fields drive the array; otherwise the latched copy does.
  assign cur_write = (state_q == IDLE) ? req_write : wr_q;
  assign cur_idx   = (state_q == IDLE) ? req_addr[AW+1:2] : idx_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis_q, err_q;
  assign cur_mis      = (state_q == IDLE) ? (req_addr[1:0] != 2'b00) : mis_q;
  assign misalign_err = resp_valid & err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (accept) mis_q <= (req_addr[1:0] != 2'b00);
      if (enter_resp) err_q <= cur_mis;
    end
  end
`else
  assign cur_mis = 1'b0;
`endif

  assign mem_we = enter_resp && cur_write && !cur_mis && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      resp_rdata <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enter_resp) resp_rdata <= (cur_write || cur_mis) ? STORE_RDATA : mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= req_write;
      idx_q   <= req_addr[AW+1:2];
      wdata_q <= req_wdata;
    end
  end

  assign dbg_state = state_q;

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (cur_idx),
    .wdata (cur_wdata),
    .rdata (mem_rdata)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY=2 and LATENCY=1) checked
// against a transaction-level model every cycle, plus directed literal checks.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 256;
  localparam int LAT0  = 2;
  localparam int LAT1  = 1;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        rv [2];
  logic        rw [2];
  logic [31:0] ra [2];
  logic [31:0] rwd [2];
  logic        rdy_o [2];
  logic        vo [2];
  logic        st_o [2];
  logic [31:0] rd_o [2];
  state_e      dbg_o [2];
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        err_o [2];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT0)) u_dut (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rdy_o[0]),
    .req_write(rw[0]), .req_addr(ra[0]), .req_wdata(rwd[0]),
    .resp_valid(vo[0]), .resp_rdata(rd_o[0]), .stall(st_o[0]),
`ifdef DMEM_MISALIGN_TRAP_EN
    .misalign_err(err_o[0]),
`endif
    .dbg_state(dbg_o[0])
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rdy_o[1]),
    .req_write(rw[1]), .req_addr(ra[1]), .req_wdata(rwd[1]),
    .resp_valid(vo[1]), .resp_rdata(rd_o[1]), .stall(st_o[1]),
`ifdef DMEM_MISALIGN_TRAP_EN
    .misalign_err(err_o[1]),
`endif
    .dbg_state(dbg_o[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  task automatic check(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL dut%0d %s: got %h expected %h at %0t", k, nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accept at edge a responds in the cycle after
  // edge a+LAT-1 and the next accept is possible at edge a+LAT+1.
  int          edge_n = 0;
  bit          model_ok = 1'b0;
  int          next_free [2] = '{0, 0};
  bit          pend [2] = '{1'b0, 1'b0};
  int          due [2];
  logic        pw [2];
  int          pidx [2];
  logic [31:0] pwd [2];
  bit          pmis [2];
  logic [31:0] mm [2][DEPTH];
  logic        exp_valid [2] = '{1'b0, 1'b0};
  logic [31:0] exp_rdata [2] = '{32'h0, 32'h0};
  logic        exp_err [2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    logic [31:0] a;
    edge_n++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        pend[k]      = 1'b0;
        exp_valid[k] = 1'b0;
        exp_rdata[k] = 32'h0;
        exp_err[k]   = 1'b0;
        next_free[k] = edge_n + 1;
        model_ok     = 1'b1;
      end else begin
        exp_valid[k] = 1'b0;
        exp_err[k]   = 1'b0;
        if (model_ok && rv[k] && edge_n >= next_free[k]) begin
          a            = ra[k];
          pend[k]      = 1'b1;
          due[k]       = edge_n + lat_of(k) - 1;
          pw[k]        = rw[k];
          pidx[k]      = int'((a >> 2) % DEPTH);
          pwd[k]       = rwd[k];
          pmis[k]      = MIS_EN && (a % 4 != 0);
          next_free[k] = edge_n + lat_of(k) + 1;
        end
        if (pend[k] && due[k] == edge_n) begin
          pend[k]      = 1'b0;
          exp_valid[k] = 1'b1;
          if (pmis[k]) begin
            exp_rdata[k] = 32'h0;
            exp_err[k]   = 1'b1;
          end else if (pw[k]) begin
            mm[k][pidx[k]] = pwd[k];
            exp_rdata[k]   = 32'h0;
          end else begin
            exp_rdata[k] = mm[k][pidx[k]];
          end
        end
      end
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    bit idle;
    if (model_ok) begin
      for (int k = 0; k < 2; k++) begin
        idle = (edge_n + 1 >= next_free[k]);
        check(k, "m_ready", rdy_o[k], idle);
        check(k, "m_valid", vo[k], exp_valid[k]);
        check(k, "m_stall", st_o[k], idle ? rv[k] : !exp_valid[k]);
        check(k, "m_rdata", rd_o[k], exp_rdata[k]);
`ifdef DMEM_MISALIGN_TRAP_EN
        check(k, "m_err", err_o[k], exp_err[k]);
`endif
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request from IDLE and checks stall/valid/rdata literally each cycle.
  task automatic xact(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_e);
    rv[k] = 1'b1; rw[k] = w; ra[k] = a; rwd[k] = d;
    #1;
    check(k, "x_stall_idle", st_o[k], 1);
    check(k, "x_ready_idle", rdy_o[k], 1);
    step();
    rv[k] = 1'b0;
    for (int i = 1; i <= lat_of(k); i++) begin
      if (i < lat_of(k)) begin
        check(k, "x_stall_busy", st_o[k], 1);
        check(k, "x_valid_busy", vo[k], 0);
      end else begin
        check(k, "x_stall_resp", st_o[k], 0);
        check(k, "x_valid_resp", vo[k], 1);
        check(k, "x_rdata", rd_o[k], exp_rd);
`ifdef DMEM_MISALIGN_TRAP_EN
        check(k, "x_err", err_o[k], exp_e);
`else
        check(k, "x_err_none", 32'(exp_e), 0);
`endif
      end
      step();
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rv[k] = 1'b0; rw[k] = 1'b0; ra[k] = 32'h0; rwd[k] = 32'h0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check(0, "rst_ready", rdy_o[0], 1);
    check(0, "rst_valid", vo[0], 0);
    check(0, "rst_rdata", rd_o[0], 0);
    check(1, "rst_ready", rdy_o[1], 1);
    step();

    // store then load, wrap-around aliasing, top word
    xact(0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0, 1'b0);
    xact(0, 1'b0, 32'h10,  32'h0, 32'hDEADBEEF, 1'b0);
    xact(0, 1'b1, 32'h400, 32'h12345678, 32'h0, 1'b0);
    xact(0, 1'b0, 32'h000, 32'h0, 32'h12345678, 1'b0);
    xact(0, 1'b1, 32'h3FC, 32'h0F0F0F0F, 32'h0, 1'b0);
    xact(0, 1'b0, 32'hBFC, 32'h0, 32'h0F0F0F0F, 1'b0);
    xact(0, 1'b1, 32'h20,  32'h11111111, 32'h0, 1'b0);
    xact(0, 1'b0, 32'h20,  32'h0, 32'h11111111, 1'b0);

    // reset while BUSY aborts the store and clears rdata
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h20; rwd[0] = 32'hA5A5A5A5;
    step();
    rv[0] = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check(0, "abort_rdata", rd_o[0], 0);
    check(0, "abort_ready", rdy_o[0], 1);
    step();
    check(0, "abort_valid", vo[0], 0);
    step();
    xact(0, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);

    // reset wins over an accept in the same cycle
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h20; rwd[0] = 32'hBAD0BAD0; rst = 1'b1;
    step();
    rst = 1'b0; rv[0] = 1'b0;
    check(0, "rstacc_ready", rdy_o[0], 1);
    step();
    step();
    xact(0, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);

    // a store presented during BUSY/RESP is ignored
    rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 32'h10;
    step();
    rw[0] = 1'b1; rwd[0] = 32'h0BADF00D;
    step();
    check(0, "ign_rdata", rd_o[0], 32'hDEADBEEF);
    rv[0] = 1'b0;
    step();
    xact(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

`ifdef DMEM_MISALIGN_TRAP_EN
    xact(0, 1'b1, 32'h22, 32'h77777777, 32'h0, 1'b1);
    xact(0, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);
`endif

    // LATENCY=1: back-to-back loads, request held through RESP
    xact(1, 1'b1, 32'h0, 32'hCAFE0001, 32'h0, 1'b0);
    xact(1, 1'b1, 32'h4, 32'hCAFE0002, 32'h0, 1'b0);
    rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 32'h0;
    #1 check(1, "b2b_ready0", rdy_o[1], 1);
    step();
    check(1, "b2b_ready1", rdy_o[1], 0);
    check(1, "b2b_valid1", vo[1], 1);
    check(1, "b2b_rdata1", rd_o[1], 32'hCAFE0001);
    ra[1] = 32'h4;
    step();
    check(1, "b2b_ready2", rdy_o[1], 1);
    check(1, "b2b_valid2", vo[1], 0);
    step();
    check(1, "b2b_valid3", vo[1], 1);
    check(1, "b2b_rdata3", rd_o[1], 32'hCAFE0002);
    rv[1] = 1'b0;
    step();
    check(1, "b2b_ready4", rdy_o[1], 1);

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The parameter DEPTH shall default to 256 and set the word count of the data memory (power of two, at least 4).
REQ-002 The parameter LATENCY shall default to 2 and set the cycles from request acceptance to response (range 1..15).
REQ-003 The block shall be clocked by clk, input, 1 bit, with reset rst, input, 1 bit, synchronous, active-high.
REQ-004 Port req_valid, input, 1: the MEM stage presents a load or store.
REQ-005 Port req_ready, output, 1: the responder can accept a request this cycle.
REQ-006 Port req_write, input, 1: 1 selects store, 0 selects load.
REQ-007 Port req_addr, input, 32: byte address.
REQ-008 Port req_wdata, input, 32: store data.
REQ-009 Port resp_valid, output, 1: one-cycle response strobe.
REQ-010 Port resp_rdata, output, 32: load data feeding the MEM/WB read-data input.
REQ-011 Port stall, output, 1: freeze request to the IF/ID/EX/MEM pipeline registers.

Function
REQ-012 The FSM shall have states IDLE, BUSY and RESP.
REQ-013 req_ready shall be 1 only in IDLE.
REQ-014 A request shall be accepted on a rising edge where req_valid=1 and req_ready=1; req_write, req_addr and req_wdata shall be latched on that edge.
REQ-015 On accept, the FSM shall move to RESP if LATENCY=1, otherwise to BUSY with the down-counter loaded to LATENCY-2.
REQ-016 BUSY shall decrement the counter each cycle and move to RESP on the edge where the counter equals 0.
REQ-017 resp_valid shall be 1 exactly in RESP, i.e. exactly LATENCY cycles after the accepting edge, for exactly one cycle; RESP shall always return to IDLE on the next edge.
REQ-018 Sustained throughput shall be one request per LATENCY+1 cycles, with no back-to-back accept from RESP.
REQ-019 The word index shall be req_addr[log2(DEPTH)+1:2]; upper address bits shall be ignored, so addresses wrap modulo DEPTH words.
REQ-020 A store shall write the memory on the edge entering RESP, and its response shall drive resp_rdata=0.
REQ-021 A load shall drive resp_rdata with the memory word read on the edge entering RESP.
REQ-022 resp_rdata shall hold its value between responses.
REQ-023 stall shall be 1 in IDLE when req_valid=1, 1 throughout BUSY, and 0 in RESP.
REQ-024 A load to an address stored by the immediately preceding request shall return the newly stored data.
REQ-025 Requests presented outside IDLE shall be ignored, not queued.

Reset
REQ-026 When rst=1, the FSM shall enter IDLE, the counter shall clear, resp_valid shall be 0 and resp_rdata shall be 0.
REQ-027 Reset shall not clear memory contents.
REQ-028 Reset asserted in BUSY shall abort the transaction: no memory write and no response.
REQ-029 Reset shall take priority over an accept in the same cycle.

Configuration
REQ-030 Defining DMEM_MISALIGN_TRAP_EN shall add output misalign_err, 1 bit, reset 0, asserted only together with resp_valid.
REQ-031 With DMEM_MISALIGN_TRAP_EN defined, a request with req_addr[1:0]!=0 shall be accepted with normal timing, shall suppress any memory write, and shall respond with resp_rdata=0 and misalign_err=1.
REQ-032 Without DMEM_MISALIGN_TRAP_EN, req_addr[1:0] shall be ignored and the misalign_err port shall not exist.

Structure
REQ-033 Shared package dmem_pkg shall hold the state enum (IDLE/BUSY/RESP), WORD_W=32 and the response-data-for-store constant (0).
REQ-034 The storage shall be a sub-module dmem_array with synchronous write and combinational read, DEPTH x WORD_W.

Verification
REQ-035 With LATENCY=2: store 0xDEADBEEF to 0x10, then load 0x10 -> resp_valid 2 cycles after each accept, load returns 0xDEADBEEF, stall pattern 1,1,0.
REQ-036 With LATENCY=1: back-to-back loads -> req_ready toggles 1,0,1; one accept every 2 cycles; requests held during RESP are not lost and are accepted in the next IDLE.
REQ-037 With DEPTH=256: store 0x12345678 to 0x400, then load 0x000 -> returns 0x12345678 (wrap).
REQ-038 rst pulsed in BUSY during a store of 0xA5A5A5A5 to 0x20 -> no resp_valid, and a later load of 0x20 returns the prior contents.
REQ-039 With DMEM_MISALIGN_TRAP_EN defined: store to 0x22 -> resp_valid with misalign_err=1 and rdata=0; a following load of 0x20 returns unchanged data.
